// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants and FSM state type for the MMIO UART.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam logic [1:0]  c_off_txdata   = 2'd0;
    localparam logic [1:0]  c_off_status   = 2'd1;
    localparam logic [1:0]  c_off_bauddiv  = 2'd2;
    localparam logic [1:0]  c_off_reserved = 2'd3;

    localparam int          c_fifo_depth   = 8;
    localparam logic [3:0]  c_fifo_full    = 4'd8;
    localparam logic [15:0] c_baud_reset   = 16'd434;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tx_fifo
// Description : 8x8 synchronous FIFO; a push into a full FIFO is accepted
//               only when a pop happens at the same edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tx_fifo
    import uart_pkg::*;
(
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       push,
    input  logic [7:0] din,
    input  logic       pop,
    output logic [7:0] dout,
    output logic       full,
    output logic       empty,
    output logic [3:0] count
);

    logic [7:0] r_mem [c_fifo_depth];
    logic [2:0] r_wr_ptr;
    logic [2:0] r_rd_ptr;
    logic [3:0] r_count;
    logic       w_do_push;
    logic       w_do_pop;

    assign empty     = (r_count == 4'd0);
    assign full      = (r_count == c_fifo_full);
    assign count     = r_count;
    assign dout      = r_mem[r_rd_ptr];
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    always_ff @(posedge CLK) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_wr_ptr <= 3'd0;
            r_rd_ptr <= 3'd0;
            r_count  <= 4'd0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 3'd1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 3'd1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 4'd1;
                2'b01:   r_count <= r_count - 4'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_mmio.sv
`default_nettype none
// ============================================================================
// Module      : uart_mmio
// Description : Memory-mapped 8N1 UART transmitter with TX FIFO, status,
//               programmable baud divisor and TX-done interrupt.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_mmio
    import uart_pkg::*;
(
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        cs,
    input  logic [9:0]  daddr,
    input  logic [31:0] ddata_w,
    input  logic        d_w,
    input  logic        d_r,
    output logic [31:0] rdata,
    output logic        tx,
    output logic        irq
);

    tx_state_t   r_state, w_state_nxt;
    logic [7:0]  r_shift, w_shift_nxt;
    logic [15:0] r_baud_cnt, w_cnt_nxt;
    logic [2:0]  r_bit_idx, w_bit_nxt;
    logic        r_tx, w_tx_nxt;
    logic [15:0] r_baud_div;
    logic        r_ie;
    logic        r_overflow;
    logic        r_irq;

    logic [1:0]  w_off;
    logic        w_wr;
    logic        w_rd;
    logic        w_push;
    logic        w_pop;
    logic        w_tick;
    logic [15:0] w_div_eff;
    logic [7:0]  w_fifo_dout;
    logic        w_fifo_full;
    logic        w_fifo_empty;
    logic [3:0]  w_fifo_count;
    logic        w_unused;

    assign w_off     = daddr[1:0];
    assign w_wr      = cs & d_w;
    assign w_rd      = cs & d_r;
    assign w_push    = w_wr & (w_off == c_off_txdata);
    assign w_tick    = (r_baud_cnt == 16'd1);
    assign w_div_eff = (r_baud_div == 16'd0) ? 16'd1 : r_baud_div;
    assign w_unused  = &{1'b0, daddr[9:2], ddata_w[31:16]};
    assign tx        = r_tx;
    assign irq       = r_irq;

    tx_fifo u_fifo (
        .CLK   (CLK),
        .RSTn  (RSTn),
        .push  (w_push),
        .din   (ddata_w[7:0]),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .full  (w_fifo_full),
        .empty (w_fifo_empty),
        .count (w_fifo_count)
    );

    always_comb begin
        rdata = 32'd0;
        if (w_rd) begin
            case (w_off)
                c_off_status:  rdata = {23'd0, w_fifo_count, r_ie, r_overflow,
                                        w_fifo_empty, w_fifo_full, (r_state != ST_IDLE)};
                c_off_bauddiv: rdata = {16'd0, r_baud_div};
                default:       rdata = 32'd0;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_baud_div <= c_baud_reset;
            r_ie       <= 1'b0;
            r_overflow <= 1'b0;
            r_irq      <= 1'b0;
        end else begin
            if (w_wr && (w_off == c_off_bauddiv)) r_baud_div <= ddata_w[15:0];
            if (w_wr && (w_off == c_off_status))  r_ie       <= ddata_w[4];
            if (w_push && w_fifo_full && !w_pop)
                r_overflow <= 1'b1;
            else if (w_wr && (w_off == c_off_status) && ddata_w[3])
                r_overflow <= 1'b0;
            r_irq <= w_fifo_empty & (r_state == ST_IDLE) & r_ie;
        end
    end

    // Counter reloads at every bit boundary so a new divisor lands on the next bit.
    always_comb begin
        w_state_nxt = r_state;
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_baud_cnt;
        w_bit_nxt   = r_bit_idx;
        w_tx_nxt    = r_tx;
        w_pop       = 1'b0;
        if (r_state != ST_IDLE)
            w_cnt_nxt = w_tick ? w_div_eff : (r_baud_cnt - 16'd1);
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty) begin
                    w_pop       = 1'b1;
                    w_shift_nxt = w_fifo_dout;
                    w_cnt_nxt   = w_div_eff;
                    w_tx_nxt    = 1'b0;
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_tick) begin
                    w_state_nxt = ST_DATA;
                    w_bit_nxt   = 3'd0;
                    w_tx_nxt    = r_shift[0];
                end
            end
            ST_DATA: begin
                if (w_tick) begin
                    if (r_bit_idx == 3'd7) begin
                        w_state_nxt = ST_STOP;
                        w_tx_nxt    = 1'b1;
                    end else begin
                        w_shift_nxt = {1'b0, r_shift[7:1]};
                        w_tx_nxt    = r_shift[1];
                        w_bit_nxt   = r_bit_idx + 3'd1;
                    end
                end
            end
            ST_STOP: begin
                if (w_tick) begin
                    if (!w_fifo_empty) begin
                        w_pop       = 1'b1;
                        w_shift_nxt = w_fifo_dout;
                        w_tx_nxt    = 1'b0;
                        w_state_nxt = ST_START;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            r_state    <= ST_IDLE;
            r_shift    <= 8'd0;
            r_baud_cnt <= 16'd0;
            r_bit_idx  <= 3'd0;
            r_tx       <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_baud_cnt <= w_cnt_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_tx       <= w_tx_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_mmio.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_mmio
// Description : Self-checking bench for uart_mmio: register vector table,
//               frame scoreboard and cycle-exact timing sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_mmio;

    logic        CLK = 1'b0;
    logic        RSTn = 1'b1;
    logic        cs = 1'b0;
    logic [9:0]  daddr = '0;
    logic [31:0] ddata_w = '0;
    logic        d_w = 1'b0;
    logic        d_r = 1'b0;
    logic [31:0] rdata;
    logic        tx;
    logic        irq;

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    logic [7:0]  sb[$];
    int          starts[$];
    bit          mon_en = 1'b0;
    bit          mon_busy = 1'b0;
    int          bdiv = 434;
    int          mon_d;
    logic [9:0]  mon_bits;
    logic [7:0]  mon_exp;

    typedef struct packed {
        logic        cs;
        logic        w;
        logic        r;
        logic [9:0]  a;
        logic [31:0] wd;
        logic [31:0] exp;
    } vec_t;
    vec_t vt[17];

    uart_mmio dut (
        .CLK     (CLK),
        .RSTn    (RSTn),
        .cs      (cs),
        .daddr   (daddr),
        .ddata_w (ddata_w),
        .d_w     (d_w),
        .d_r     (d_r),
        .rdata   (rdata),
        .tx      (tx),
        .irq     (irq)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame decoder: samples mid-bit and pops the expected byte from the scoreboard.
    always begin
        @(negedge CLK);
        if (mon_en && RSTn && tx === 1'b0) begin
            mon_busy = 1'b1;
            mon_d = (bdiv == 0) ? 1 : bdiv;
            starts.push_back(cyc);
            for (int j = 0; j < 10; j++) begin
                repeat (mon_d / 2) @(negedge CLK);
                mon_bits[j] = tx;
                if (j < 9) repeat (mon_d - mon_d / 2) @(negedge CLK);
                else       repeat (mon_d - mon_d / 2 - 1) @(negedge CLK);
            end
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL frame_unexpected: got frame 0x%03h expected none", mon_bits);
            end else begin
                mon_exp = sb.pop_front();
                check("frame", {22'd0, mon_bits}, {22'd0, 1'b1, mon_exp, 1'b0});
            end
            mon_busy = 1'b0;
        end
    end

    task automatic do_reset();
        mon_en = 1'b0;
        cs = 1'b0; d_w = 1'b0; d_r = 1'b0; daddr = '0; ddata_w = '0;
        @(negedge CLK);
        RSTn = 1'b0;
        repeat (2) @(negedge CLK);
        RSTn = 1'b1;
        sb.delete();
        starts.delete();
        bdiv = 434;
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        @(negedge CLK);
        cs = 1'b1; d_w = 1'b1; daddr = a; ddata_w = d;
        @(posedge CLK);
        #1;
        cs = 1'b0; d_w = 1'b0;
    endtask

    task automatic rd(input logic [9:0] a, output logic [31:0] v);
        cs = 1'b1; d_r = 1'b1; daddr = a;
        #1;
        v = rdata;
        cs = 1'b0; d_r = 1'b0;
    endtask

    task automatic send(input logic [7:0] b, input bit accepted);
        wr(10'h000, {24'hC0FFEE, b});
        if (accepted) sb.push_back(b);
    endtask

    task automatic drain(input int limit);
        int n = 0;
        while ((sb.size() != 0 || mon_busy) && n < limit) begin
            @(posedge CLK);
            n++;
        end
        #1;
        check("drain_left", 32'(sb.size()) + 32'(mon_busy), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [7:0]  b;
        int          e1, lows;
        logic        exp_tx;

        vt[0]  = '{1'b1, 1'b0, 1'b1, 10'h002, 32'h0,        32'h1B2};
        vt[1]  = '{1'b1, 1'b0, 1'b1, 10'h001, 32'h0,        32'h4};
        vt[2]  = '{1'b1, 1'b1, 1'b1, 10'h3FE, 32'hFFFF0007, 32'h1B2};
        vt[3]  = '{1'b1, 1'b0, 1'b1, 10'h002, 32'h0,        32'h7};
        vt[4]  = '{1'b0, 1'b1, 1'b1, 10'h002, 32'h9,        32'h0};
        vt[5]  = '{1'b1, 1'b0, 1'b1, 10'h002, 32'h0,        32'h7};
        vt[6]  = '{1'b1, 1'b1, 1'b0, 10'h155, 32'hFFFFFFF7, 32'h0};
        vt[7]  = '{1'b1, 1'b0, 1'b1, 10'h001, 32'h0,        32'h14};
        vt[8]  = '{1'b0, 1'b1, 1'b0, 10'h001, 32'h0,        32'h0};
        vt[9]  = '{1'b1, 1'b0, 1'b1, 10'h001, 32'h0,        32'h14};
        vt[10] = '{1'b1, 1'b1, 1'b1, 10'h2A3, 32'hFFFFFFFF, 32'h0};
        vt[11] = '{1'b1, 1'b0, 1'b1, 10'h003, 32'h0,        32'h0};
        vt[12] = '{1'b1, 1'b0, 1'b1, 10'h104, 32'h0,        32'h0};
        vt[13] = '{1'b1, 1'b1, 1'b1, 10'h001, 32'h0,        32'h14};
        vt[14] = '{1'b1, 1'b0, 1'b1, 10'h001, 32'h0,        32'h4};
        vt[15] = '{1'b1, 1'b1, 1'b0, 10'h002, 32'h00010000, 32'h0};
        vt[16] = '{1'b1, 1'b0, 1'b1, 10'h002, 32'h0,        32'h0};

        // Reset state and register map
        do_reset();
        #1;
        check("reset_tx", {31'd0, tx}, 32'd1);
        check("reset_irq", {31'd0, irq}, 32'd0);
        for (int i = 0; i < 17; i++) begin
            @(negedge CLK);
            cs = vt[i].cs; d_w = vt[i].w; d_r = vt[i].r; daddr = vt[i].a; ddata_w = vt[i].wd;
            #1;
            if (vt[i].r) check($sformatf("vec%0d_rdata", i), rdata, vt[i].exp);
            @(posedge CLK);
            #1;
            cs = 1'b0; d_w = 1'b0; d_r = 1'b0;
        end

        // Single frame at divisor 3, cycle exact
        do_reset();
        wr(10'h002, 32'd3);
        bdiv = 3;
        mon_en = 1'b1;
        b = 8'hA5;
        send(b, 1'b1);
        check("a5_tx_at_push", {31'd0, tx}, 32'd1);
        rd(10'h001, v);
        check("a5_status_at_push", v, 32'h20);
        for (int i = 0; i < 30; i++) begin
            @(posedge CLK);
            #1;
            exp_tx = (i < 3) ? 1'b0 : (i < 27) ? b[(i - 3) / 3] : 1'b1;
            check($sformatf("a5_tx_t%0d", i), {31'd0, tx}, {31'd0, exp_tx});
        end
        rd(10'h001, v);
        check("a5_busy_in_stop", v, 32'h5);
        @(posedge CLK);
        #1;
        rd(10'h001, v);
        check("a5_idle", v, 32'h4);
        drain(100);

        // Fill FIFO, overflow, clear, push-with-pop while full, back-to-back frames
        do_reset();
        wr(10'h002, 32'd20);
        bdiv = 20;
        mon_en = 1'b1;
        e1 = 0;
        for (int i = 0; i < 9; i++) begin
            send(8'h10 + 8'(i), 1'b1);
            if (i == 0) e1 = cyc;
        end
        rd(10'h001, v);
        check("fill9_status", v, 32'h103);
        send(8'hEE, 1'b0);
        rd(10'h001, v);
        check("overflow_status", v, 32'h10B);
        wr(10'h001, 32'h8);
        rd(10'h001, v);
        check("overflow_cleared", v, 32'h103);
        while (cyc < e1 + 200) begin
            @(posedge CLK);
            #1;
        end
        send(8'h77, 1'b1);
        rd(10'h001, v);
        check("push_pop_full", v, 32'h103);
        drain(3000);
        check("frame_count", 32'(starts.size()), 32'd10);
        for (int i = 1; i < 4 && i < starts.size(); i++)
            check($sformatf("b2b_gap%0d", i), 32'(starts[i] - starts[i-1]), 32'd200);

        // Divisor change 3 -> 5 during data bit 2
        do_reset();
        wr(10'h002, 32'd3);
        b = 8'h55;
        send(b, 1'b0);
        for (int t = 0; t < 42; t++) begin
            @(posedge CLK);
            #1;
            if (t == 10) begin cs = 1'b0; d_w = 1'b0; end
            exp_tx = (t < 3) ? 1'b0 : (t < 12) ? b[(t - 3) / 3] :
                     (t < 37) ? b[3 + (t - 12) / 5] : 1'b1;
            check($sformatf("baudchg_tx_t%0d", t), {31'd0, tx}, {31'd0, exp_tx});
            if (t == 9) begin cs = 1'b1; d_w = 1'b1; daddr = 10'h002; ddata_w = 32'd5; end
        end
        @(posedge CLK);
        #1;
        rd(10'h001, v);
        check("baudchg_idle", v, 32'h4);

        // Reset during data bit 4
        do_reset();
        wr(10'h002, 32'd3);
        send(8'h0F, 1'b0);
        for (int t = 0; t <= 16; t++) begin
            @(posedge CLK);
            #1;
        end
        check("pre_reset_tx", {31'd0, tx}, 32'd0);
        #2;
        RSTn = 1'b0;
        #1;
        check("async_reset_tx", {31'd0, tx}, 32'd1);
        @(negedge CLK);
        RSTn = 1'b1;
        #1;
        rd(10'h001, v);
        check("post_reset_status", v, 32'h4);
        rd(10'h002, v);
        check("post_reset_bauddiv", v, 32'h1B2);
        check("post_reset_irq", {31'd0, irq}, 32'd0);
        lows = 0;
        for (int t = 0; t < 40; t++) begin
            @(posedge CLK);
            #1;
            if (tx !== 1'b1) lows++;
        end
        check("no_resume_lows", 32'(lows), 32'd0);

        // Interrupt timing and cs-gated writes
        do_reset();
        wr(10'h002, 32'd3);
        bdiv = 3;
        mon_en = 1'b1;
        wr(10'h001, 32'h10);
        check("irq_ie_edge", {31'd0, irq}, 32'd0);
        @(posedge CLK);
        #1;
        check("irq_idle", {31'd0, irq}, 32'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            cs = 1'b0; d_w = 1'b1; daddr = (i == 0) ? 10'h001 : 10'h000; ddata_w = 32'h0000_0008;
            @(posedge CLK);
            #1;
            d_w = 1'b0;
            rd(10'h001, v);
            check($sformatf("cs0_write%0d_status", i), v, 32'h14);
        end
        send(8'h3C, 1'b1);
        check("irq_at_push", {31'd0, irq}, 32'd1);
        for (int t = 1; t <= 31; t++) begin
            @(posedge CLK);
            #1;
            if (t == 1) check("irq_low_sending", {31'd0, irq}, 32'd0);
        end
        check("irq_at_idle_return", {31'd0, irq}, 32'd0);
        rd(10'h001, v);
        check("irq_status_idle", v, 32'h14);
        @(posedge CLK);
        #1;
        check("irq_rise", {31'd0, irq}, 32'd1);
        drain(100);

        // Divisor 0 behaves as 1
        do_reset();
        wr(10'h002, 32'd0);
        bdiv = 0;
        mon_en = 1'b1;
        send(8'hC3, 1'b1);
        repeat (10) @(posedge CLK);
        #1;
        rd(10'h001, v);
        check("div0_busy_stop", v, 32'h5);
        @(posedge CLK);
        #1;
        rd(10'h001, v);
        check("div0_idle", v, 32'h4);
        drain(50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_mmio.md
UART_MMIO -- requirements
Module: uart_mmio

Interface
REQ-001 CLK  input  1  system clock; all state updates on rising edge.
REQ-002 RSTn  input  1  reset, asynchronous, active-low.
REQ-003 cs  input  1  chip select from data-bus address decode; qualifies d_w/d_r.
REQ-004 daddr  input  10  word address from core; only daddr[1:0] used as register offset.
REQ-005 ddata_w  input  32  store data from core.
REQ-006 d_w  input  1  store strobe; write committed at the rising edge where cs & d_w.
REQ-007 d_r  input  1  load strobe; read is combinational in the same cycle.
REQ-008 rdata  output  32  read data; 32'd0 when !(cs & d_r).
REQ-009 tx  output  1  serial output, registered, idle high.
REQ-010 irq  output  1  level: TX FIFO empty AND FSM in IDLE AND IE set; registered.

Function
REQ-011 Offset 0 TXDATA: write pushes ddata_w[7:0] into 8-deep TX FIFO; reads return 0.
REQ-012 Offset 1 STATUS read: bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overflow (sticky), bit4 IE, bits[8:5] count 0..8, others 0.
REQ-013 STATUS write: bit3=1 clears overflow; bit4 written into IE; other bits ignored.
REQ-014 Offset 2 BAUDDIV: R/W bits[15:0], upper bits read 0; bit period = BAUDDIV clocks, value 0 treated as 1.
REQ-015 Offset 3 reserved: writes ignored, reads 0.
REQ-016 Push when full and no simultaneous pop: byte dropped, overflow set at that edge.
REQ-017 Push when full with simultaneous pop: push accepted, count stays 8, overflow unchanged.
REQ-018 FIFO pointers 3-bit, wrap modulo 8; count 4-bit.
REQ-019 FSM states IDLE, START, DATA, STOP; frame 8N1, LSB first.
REQ-020 IDLE: if FIFO non-empty, pop at that edge, load shift register, load baud counter, go START; tx low from that edge.
REQ-021 START: hold tx=0 one bit period, then DATA with bit index 0.
REQ-022 DATA: tx = shift[0] per bit period; after bit index 7 go STOP.
REQ-023 STOP: tx=1 one bit period; then IDLE, or directly START if FIFO non-empty (back-to-back, no idle gap).
REQ-024 Baud counter reloads from BAUDDIV at every bit boundary; BAUDDIV write mid-frame takes effect at the next bit boundary.
REQ-025 Latency: push at edge k into empty FIFO with FSM IDLE -> FIFO visible at k, pop and tx falls at edge k+1.
REQ-026 d_w and d_r both high: write committed, rdata shows pre-write value.
REQ-027 cs low: no register or FIFO change regardless of d_w.

Reset
REQ-028 RSTn low: tx=1, irq=0, FSM IDLE, FIFO empty (pointers, count 0), overflow=0, IE=0, BAUDDIV=16'd434, shift register 0.
REQ-029 Reset mid-frame aborts the frame immediately; tx returns high asynchronously; no partial byte resumes.

Structure
REQ-030 Shared package uart_pkg: register offsets, FIFO depth 8, reset divisor 434, FSM state enum.
REQ-031 One sub-module tx_fifo (8x8 synchronous FIFO, push/pop/full/empty/count, simultaneous push-pop rule of REQ-017).
REQ-032 Register decode, baud counter and FSM live in uart_mmio.

Verification
REQ-033 Reset, BAUDDIV=3, write TXDATA 8'hA5 -> tx low next edge, bits 1,0,1,0,0,1,0,1 each 3 clocks, stop high 3 clocks, frame 30 clocks, busy clears.
REQ-034 Write 9 bytes back-to-back with FIFO initially empty and FSM IDLE -> first pops at edge 2, all 9 accepted, no overflow; 10 pushes into full FIFO -> overflow bit set, STATUS bit3 write-1 clears it.
REQ-035 Two bytes queued -> STOP of first followed directly by START of second, no idle cycle.
REQ-036 BAUDDIV changed 3->5 during DATA bit 2 -> bit 2 stays 3 clocks, bit 3 onward 5 clocks.
REQ-037 RSTn pulsed low during DATA bit 4 -> tx=1 immediately, FIFO empty, STATUS reads 0x00000004, BAUDDIV reads 434.
REQ-038 IE=1, single byte sent -> irq rises one edge after FSM returns IDLE with FIFO empty; cs=0 writes never change STATUS.
